// File: rtl/csr_trap_sequencer_pkg.sv
// Shared definitions for the trap sequencer: CSR addresses, mstatus fields,
// the fixed external-interrupt cause, sequencer states and mstatus update helpers.
package csr_trap_sequencer_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  localparam int unsigned MSTATUS_MIE    = 3;
  localparam int unsigned MSTATUS_MPIE   = 7;
  localparam int unsigned MSTATUS_MPP_HI = 12;
  localparam int unsigned MSTATUS_MPP_LO = 11;

  localparam logic [31:0] INT_CAUSE_EXT = 32'h8000_000B;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_W_MEPC,
    ST_W_MCAUSE,
    ST_W_MTVAL,
    ST_W_MSTATUS,
    ST_M_MSTATUS,
    ST_REDIRECT
  } state_e;

  // Trap entry: stack MIE into MPIE, disable interrupts, record M-mode as previous.
  function automatic logic [31:0] trap_mstatus(input logic [31:0] ms);
    logic [31:0] r;
    r = ms;
    r[MSTATUS_MPIE] = ms[MSTATUS_MIE];
    r[MSTATUS_MIE]  = 1'b0;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return r;
  endfunction

  // MRET: restore MIE from MPIE and set MPIE.
  function automatic logic [31:0] mret_mstatus(input logic [31:0] ms);
    logic [31:0] r;
    r = ms;
    r[MSTATUS_MIE]  = ms[MSTATUS_MPIE];
    r[MSTATUS_MPIE] = 1'b1;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return r;
  endfunction

endpackage

// File: rtl/csr_trap_sequencer_trap_target_calc.sv
// Combinational redirect target: mepc for MRET, mtvec base for traps,
// or base + 4*cause for interrupts when mtvec selects vectored mode.
module trap_target_calc
  import csr_trap_sequencer_pkg::*;
(
  input  logic [31:0] mtvec,
  input  logic [31:0] cause,
  input  logic        is_int,
  input  logic        is_mret,
  input  logic [31:0] mepc,
  output logic [31:0] target
);

  logic [31:0] base;
  logic [31:0] vec_off;
  logic        cause_unused;

  assign base    = {mtvec[31:2], 2'b00};
  // cause[30:0] << 2 truncated to 32 bits; bits 31:30 shift out.
  assign vec_off = {cause[29:0], 2'b00};
  assign cause_unused = ^cause[31:30];

  always_comb begin
    target = base;
    if (is_mret) begin
      target = mepc;
    end else if (is_int && (mtvec[1:0] == 2'b01)) begin
      target = base + vec_off;
    end
  end

endmodule

// File: rtl/csr_trap_sequencer.sv
// Owns the CSR-file write port: passes pipeline writes through while idle and
// sequences trap-entry / MRET CSR updates followed by a one-cycle redirect.
module csr_trap_sequencer
  import csr_trap_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Trap_Req,
  input  logic [31:0] Trap_Cause,
  input  logic [31:0] Trap_PC,
  input  logic [31:0] Trap_Val,
  input  logic        Int_Req,
  input  logic        Mret_Req,
  input  logic [31:0] Int_PC,
  input  logic [31:0] CSR_mstatus,
  input  logic [31:0] CSR_mtvec,
  input  logic [31:0] CSR_mepc,
  input  logic        Pipe_CSR_WE,
  input  logic [11:0] Pipe_CSR_Addr,
  input  logic [31:0] Pipe_CSR_WData,
  output logic        CSR_WE,
  output logic [11:0] CSR_Addr,
  output logic [31:0] CSR_WData,
  output logic        Trap_Ack,
  output logic        Stall,
  output logic        Flush,
  output logic        Redirect_Valid,
  output logic [31:0] Redirect_PC
);

  state_e      state_q, state_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] tval_q, tval_d;
  logic        is_int_q, is_int_d;
  logic        is_mret_q, is_mret_d;
  logic [31:0] target;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cause_q   <= '0;
      pc_q      <= '0;
      tval_q    <= '0;
      is_int_q  <= 1'b0;
      is_mret_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cause_q   <= cause_d;
      pc_q      <= pc_d;
      tval_q    <= tval_d;
      is_int_q  <= is_int_d;
      is_mret_q <= is_mret_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cause_d        = cause_q;
    pc_d           = pc_q;
    tval_d         = tval_q;
    is_int_d       = is_int_q;
    is_mret_d      = is_mret_q;
    Trap_Ack       = 1'b0;
    CSR_WE         = 1'b0;
    CSR_Addr       = '0;
    CSR_WData      = '0;
    Redirect_Valid = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (Trap_Req) begin
          Trap_Ack  = 1'b1;
          cause_d   = Trap_Cause;
          pc_d      = Trap_PC;
          tval_d    = Trap_Val;
          is_int_d  = 1'b0;
          is_mret_d = 1'b0;
          state_d   = ST_W_MEPC;
        end else if (Int_Req && CSR_mstatus[MSTATUS_MIE]) begin
          Trap_Ack  = 1'b1;
          cause_d   = INT_CAUSE_EXT;
          pc_d      = Int_PC;
          tval_d    = '0;
          is_int_d  = 1'b1;
          is_mret_d = 1'b0;
          state_d   = ST_W_MEPC;
        end else if (Mret_Req) begin
          Trap_Ack  = 1'b1;
          is_int_d  = 1'b0;
          is_mret_d = 1'b1;
          state_d   = ST_M_MSTATUS;
        end else begin
          CSR_WE    = Pipe_CSR_WE;
          CSR_Addr  = Pipe_CSR_Addr;
          CSR_WData = Pipe_CSR_WData;
        end
      end
      ST_W_MEPC: begin
        CSR_WE    = 1'b1;
        CSR_Addr  = CSR_MEPC;
        CSR_WData = {pc_q[31:2], 2'b00};
        state_d   = ST_W_MCAUSE;
      end
      ST_W_MCAUSE: begin
        CSR_WE    = 1'b1;
        CSR_Addr  = CSR_MCAUSE;
        CSR_WData = cause_q;
        state_d   = ST_W_MTVAL;
      end
      ST_W_MTVAL: begin
        CSR_WE    = 1'b1;
        CSR_Addr  = CSR_MTVAL;
        CSR_WData = tval_q;
        state_d   = ST_W_MSTATUS;
      end
      ST_W_MSTATUS: begin
        CSR_WE    = 1'b1;
        CSR_Addr  = CSR_MSTATUS;
        CSR_WData = trap_mstatus(CSR_mstatus);
        state_d   = ST_REDIRECT;
      end
      ST_M_MSTATUS: begin
        CSR_WE    = 1'b1;
        CSR_Addr  = CSR_MSTATUS;
        CSR_WData = mret_mstatus(CSR_mstatus);
        state_d   = ST_REDIRECT;
      end
      ST_REDIRECT: begin
        Redirect_Valid = 1'b1;
        state_d        = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  trap_target_calc u_target (
    .mtvec   (CSR_mtvec),
    .cause   (cause_q),
    .is_int  (is_int_q),
    .is_mret (is_mret_q),
    .mepc    (CSR_mepc),
    .target  (target)
  );

  assign Stall       = (state_q != ST_IDLE) | Trap_Ack;
  assign Flush       = Redirect_Valid;
  assign Redirect_PC = Redirect_Valid ? target : RESET_PC;

endmodule

// File: tb/tb_csr_trap_sequencer.sv
// Directed bench for csr_trap_sequencer with hand-computed expected values.
module tb_csr_trap_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        Trap_Req, Int_Req, Mret_Req, Pipe_CSR_WE;
  logic [31:0] Trap_Cause, Trap_PC, Trap_Val, Int_PC;
  logic [31:0] CSR_mstatus, CSR_mtvec, CSR_mepc, Pipe_CSR_WData;
  logic [11:0] Pipe_CSR_Addr;
  logic        CSR_WE, Trap_Ack, Stall, Flush, Redirect_Valid;
  logic [11:0] CSR_Addr;
  logic [31:0] CSR_WData, Redirect_PC;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  csr_trap_sequencer #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .Trap_Req       (Trap_Req),
    .Trap_Cause     (Trap_Cause),
    .Trap_PC        (Trap_PC),
    .Trap_Val       (Trap_Val),
    .Int_Req        (Int_Req),
    .Mret_Req       (Mret_Req),
    .Int_PC         (Int_PC),
    .CSR_mstatus    (CSR_mstatus),
    .CSR_mtvec      (CSR_mtvec),
    .CSR_mepc       (CSR_mepc),
    .Pipe_CSR_WE    (Pipe_CSR_WE),
    .Pipe_CSR_Addr  (Pipe_CSR_Addr),
    .Pipe_CSR_WData (Pipe_CSR_WData),
    .CSR_WE         (CSR_WE),
    .CSR_Addr       (CSR_Addr),
    .CSR_WData      (CSR_WData),
    .Trap_Ack       (Trap_Ack),
    .Stall          (Stall),
    .Flush          (Flush),
    .Redirect_Valid (Redirect_Valid),
    .Redirect_PC    (Redirect_PC)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change 1ns after posedge; outputs are checked at the following negedge,
  // then time advances to 1ns after the next posedge.
  task automatic step(input string tag, input logic ack, input logic stall,
                      input logic we, input logic [11:0] addr, input logic [31:0] data,
                      input logic rv, input logic [31:0] rpc);
    #4;
    check({tag, ".ack"},   {31'd0, Trap_Ack}, {31'd0, ack});
    check({tag, ".stall"}, {31'd0, Stall}, {31'd0, stall});
    check({tag, ".we"},    {31'd0, CSR_WE}, {31'd0, we});
    if (we) begin
      check({tag, ".addr"}, {20'd0, CSR_Addr}, {20'd0, addr});
      check({tag, ".data"}, CSR_WData, data);
    end
    check({tag, ".rv"},    {31'd0, Redirect_Valid}, {31'd0, rv});
    check({tag, ".flush"}, {31'd0, Flush}, {31'd0, rv});
    check({tag, ".rpc"},   Redirect_PC, rpc);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    Trap_Req = 0; Int_Req = 0; Mret_Req = 0;
    Trap_Cause = '0; Trap_PC = '0; Trap_Val = '0; Int_PC = '0;
    CSR_mstatus = '0; CSR_mtvec = '0; CSR_mepc = '0;
    Pipe_CSR_WE = 1'b1; Pipe_CSR_Addr = 12'h123; Pipe_CSR_WData = 32'h55;

    // Reset: control outputs idle, pipeline write passes through
    @(posedge clk); #1;
    step("reset", 0, 0, 1, 12'h123, 32'h55, 0, 32'h0);
    rst_n = 1'b1;
    Pipe_CSR_WE = 1'b0;
    step("idle", 0, 0, 0, 12'h0, 32'h0, 0, 32'h0);

    // Synchronous exception
    Trap_Req = 1; Trap_PC = 32'h100; Trap_Cause = 32'h2; Trap_Val = 32'hDEAD;
    CSR_mtvec = 32'h200; CSR_mstatus = 32'h8;
    step("exc.t0", 1, 1, 0, 12'h0, 32'h0, 0, 32'h0);
    Trap_Req = 0;
    step("exc.t1", 0, 1, 1, 12'h341, 32'h100, 0, 32'h0);
    step("exc.t2", 0, 1, 1, 12'h342, 32'h2, 0, 32'h0);
    step("exc.t3", 0, 1, 1, 12'h343, 32'hDEAD, 0, 32'h0);
    step("exc.t4", 0, 1, 1, 12'h300, 32'h1880, 0, 32'h0);
    step("exc.t5", 0, 1, 0, 12'h0, 32'h0, 1, 32'h200);
    step("exc.t6", 0, 0, 0, 12'h0, 32'h0, 0, 32'h0);

    // Vectored interrupt; Int_Req drops after acceptance
    Int_Req = 1; CSR_mstatus = 32'h8; CSR_mtvec = 32'h201; Int_PC = 32'h44;
    step("vint.t0", 1, 1, 0, 12'h0, 32'h0, 0, 32'h0);
    Int_Req = 0;
    step("vint.t1", 0, 1, 1, 12'h341, 32'h44, 0, 32'h0);
    step("vint.t2", 0, 1, 1, 12'h342, 32'h8000000B, 0, 32'h0);
    step("vint.t3", 0, 1, 1, 12'h343, 32'h0, 0, 32'h0);
    step("vint.t4", 0, 1, 1, 12'h300, 32'h1880, 0, 32'h0);
    step("vint.t5", 0, 1, 0, 12'h0, 32'h0, 1, 32'h22C);
    step("vint.t6", 0, 0, 0, 12'h0, 32'h0, 0, 32'h0);

    // Masked interrupt: pipeline write passes through
    Int_Req = 1; CSR_mstatus = 32'h0;
    Pipe_CSR_WE = 1; Pipe_CSR_Addr = 12'h305; Pipe_CSR_WData = 32'hCAFE0000;
    step("mask.c0", 0, 0, 1, 12'h305, 32'hCAFE0000, 0, 32'h0);
    step("mask.c1", 0, 0, 1, 12'h305, 32'hCAFE0000, 0, 32'h0);
    Int_Req = 0; Pipe_CSR_WE = 0;

    // MRET
    Mret_Req = 1; CSR_mepc = 32'h104; CSR_mstatus = 32'h1880;
    step("mret.t0", 1, 1, 0, 12'h0, 32'h0, 0, 32'h0);
    Mret_Req = 0;
    step("mret.t1", 0, 1, 1, 12'h300, 32'h1888, 0, 32'h0);
    step("mret.t2", 0, 1, 0, 12'h0, 32'h0, 1, 32'h104);
    step("mret.t3", 0, 0, 0, 12'h0, 32'h0, 0, 32'h0);

    // Priority: trap wins over MRET and pipeline write; MRET follows on return
    Trap_Req = 1; Mret_Req = 1; Trap_PC = 32'h10B; Trap_Cause = 32'h4; Trap_Val = 32'h0;
    CSR_mtvec = 32'h200; CSR_mstatus = 32'h8; CSR_mepc = 32'h104;
    Pipe_CSR_WE = 1; Pipe_CSR_Addr = 12'h7FF; Pipe_CSR_WData = 32'h1;
    step("pri.t0", 1, 1, 0, 12'h0, 32'h0, 0, 32'h0);
    Trap_Req = 0;
    step("pri.t1", 0, 1, 1, 12'h341, 32'h108, 0, 32'h0);
    step("pri.t2", 0, 1, 1, 12'h342, 32'h4, 0, 32'h0);
    step("pri.t3", 0, 1, 1, 12'h343, 32'h0, 0, 32'h0);
    step("pri.t4", 0, 1, 1, 12'h300, 32'h1880, 0, 32'h0);
    step("pri.t5", 0, 1, 0, 12'h0, 32'h0, 1, 32'h200);
    step("pri.t6", 1, 1, 0, 12'h0, 32'h0, 0, 32'h0);
    Mret_Req = 0;
    step("pri.t7", 0, 1, 1, 12'h300, 32'h1880, 0, 32'h0);
    step("pri.t8", 0, 1, 0, 12'h0, 32'h0, 1, 32'h104);
    step("pri.t9", 0, 0, 1, 12'h7FF, 32'h1, 0, 32'h0);
    Pipe_CSR_WE = 0;

    // Reset during W_MTVAL, then a fresh trap restarts from W_MEPC
    Trap_Req = 1; Trap_PC = 32'h300; Trap_Cause = 32'h5; Trap_Val = 32'h7;
    step("rst.t0", 1, 1, 0, 12'h0, 32'h0, 0, 32'h0);
    Trap_Req = 0;
    step("rst.t1", 0, 1, 1, 12'h341, 32'h300, 0, 32'h0);
    step("rst.t2", 0, 1, 1, 12'h342, 32'h5, 0, 32'h0);
    #2;
    check("rst.mtval_addr", {20'd0, CSR_Addr}, 32'h343);
    rst_n = 1'b0;
    #1;
    check("rst.stall", {31'd0, Stall}, 32'h0);
    check("rst.we",    {31'd0, CSR_WE}, 32'h0);
    check("rst.ack",   {31'd0, Trap_Ack}, 32'h0);
    check("rst.rv",    {31'd0, Redirect_Valid}, 32'h0);
    check("rst.flush", {31'd0, Flush}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    Trap_Req = 1; Trap_PC = 32'h400; Trap_Cause = 32'h6; Trap_Val = 32'h9;
    step("rst.re0", 1, 1, 0, 12'h0, 32'h0, 0, 32'h0);
    Trap_Req = 0;
    step("rst.re1", 0, 1, 1, 12'h341, 32'h400, 0, 32'h0);
    step("rst.re2", 0, 1, 1, 12'h342, 32'h6, 0, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
